// File: rtl/branch_rs_if.sv
// rtl/branch_rs_if.sv - dispatch, result-bus and issue signals of the branch reservation station
interface branch_rs_if #(
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6,
    parameter int DATA_W = 32
);
    logic              disp_valid;
    logic [OP_W-1:0]   disp_op;
    logic [DATA_W-1:0] disp_vj;
    logic [DATA_W-1:0] disp_vk;
    logic              disp_qj_busy;
    logic              disp_qk_busy;
    logic [TAG_W-1:0]  disp_qj;
    logic [TAG_W-1:0]  disp_qk;
    logic [DATA_W-1:0] disp_imm;
    logic [DATA_W-1:0] disp_pc;
    logic [TAG_W-1:0]  disp_dest;
    logic              full;

    logic              cdb_a_valid;
    logic [TAG_W-1:0]  cdb_a_tag;
    logic [DATA_W-1:0] cdb_a_data;
    logic              cdb_b_valid;
    logic [TAG_W-1:0]  cdb_b_tag;
    logic [DATA_W-1:0] cdb_b_data;

    logic              exec_enable;
    logic [OP_W-1:0]   exec_op;
    logic [DATA_W-1:0] exec_reg1;
    logic [DATA_W-1:0] exec_reg2;
    logic [DATA_W-1:0] exec_imm;
    logic [DATA_W-1:0] exec_pc;
    logic [TAG_W-1:0]  exec_dest;

    modport master (
        output disp_valid, disp_op, disp_vj, disp_vk, disp_qj_busy, disp_qk_busy,
               disp_qj, disp_qk, disp_imm, disp_pc, disp_dest,
               cdb_a_valid, cdb_a_tag, cdb_a_data, cdb_b_valid, cdb_b_tag, cdb_b_data,
        input  full, exec_enable, exec_op, exec_reg1, exec_reg2, exec_imm, exec_pc, exec_dest
    );

    modport slave (
        input  disp_valid, disp_op, disp_vj, disp_vk, disp_qj_busy, disp_qk_busy,
               disp_qj, disp_qk, disp_imm, disp_pc, disp_dest,
               cdb_a_valid, cdb_a_tag, cdb_a_data, cdb_b_valid, cdb_b_tag, cdb_b_data,
        output full, exec_enable, exec_op, exec_reg1, exec_reg2, exec_imm, exec_pc, exec_dest
    );
endinterface

// File: rtl/branch_rs.sv
// rtl/branch_rs.sv - reservation station and issue scheduler for the branch unit
module branch_rs #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6,
    parameter int DATA_W = 32
) (
    input logic       clk,
    input logic       rst,
    input logic       rdy,
    input logic       clear,
    branch_rs_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  qj_busy;
    logic [DEPTH-1:0]  qk_busy;
    logic [OP_W-1:0]   op   [DEPTH];
    logic [DATA_W-1:0] vj   [DEPTH];
    logic [DATA_W-1:0] vk   [DEPTH];
    logic [TAG_W-1:0]  qj   [DEPTH];
    logic [TAG_W-1:0]  qk   [DEPTH];
    logic [DATA_W-1:0] imm  [DEPTH];
    logic [DATA_W-1:0] pc   [DEPTH];
    logic [TAG_W-1:0]  dest [DEPTH];

    logic              full_q;
    logic              exec_enable_q;
    logic [OP_W-1:0]   exec_op_q;
    logic [DATA_W-1:0] exec_reg1_q;
    logic [DATA_W-1:0] exec_reg2_q;
    logic [DATA_W-1:0] exec_imm_q;
    logic [DATA_W-1:0] exec_pc_q;
    logic [TAG_W-1:0]  exec_dest_q;

    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic              issue_found;
    logic [IDX_W-1:0]  issue_idx;
    logic              do_disp;
    logic [DEPTH-1:0]  busy_nxt;
    logic [DATA_W-1:0] byp_vj;
    logic [DATA_W-1:0] byp_vk;
    logic              byp_qj_busy;
    logic              byp_qk_busy;

    assign bus.full        = full_q;
    assign bus.exec_enable = exec_enable_q;
    assign bus.exec_op     = exec_op_q;
    assign bus.exec_reg1   = exec_reg1_q;
    assign bus.exec_reg2   = exec_reg2_q;
    assign bus.exec_imm    = exec_imm_q;
    assign bus.exec_pc     = exec_pc_q;
    assign bus.exec_dest   = exec_dest_q;

    // Lowest free slot and lowest ready slot, both from registered state only
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        issue_found = 1'b0;
        issue_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (busy[i] && !qj_busy[i] && !qk_busy[i]) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
        end
    end

    // Occupancy after this edge's issue and dispatch; feeds the registered full flag
    always_comb begin
        do_disp  = bus.disp_valid && !full_q && free_found;
        busy_nxt = busy;
        if (issue_found) busy_nxt[issue_idx] = 1'b0;
        if (do_disp)     busy_nxt[free_idx]  = 1'b1;
    end

    // Operands resolved by a result broadcast on the same edge as their dispatch; ALU bus wins ties
    always_comb begin
        byp_vj      = bus.disp_vj;
        byp_qj_busy = bus.disp_qj_busy;
        byp_vk      = bus.disp_vk;
        byp_qk_busy = bus.disp_qk_busy;
        if (bus.disp_qj_busy) begin
            if (bus.cdb_a_valid && bus.cdb_a_tag == bus.disp_qj) begin
                byp_vj      = bus.cdb_a_data;
                byp_qj_busy = 1'b0;
            end else if (bus.cdb_b_valid && bus.cdb_b_tag == bus.disp_qj) begin
                byp_vj      = bus.cdb_b_data;
                byp_qj_busy = 1'b0;
            end
        end
        if (bus.disp_qk_busy) begin
            if (bus.cdb_a_valid && bus.cdb_a_tag == bus.disp_qk) begin
                byp_vk      = bus.cdb_a_data;
                byp_qk_busy = 1'b0;
            end else if (bus.cdb_b_valid && bus.cdb_b_tag == bus.disp_qk) begin
                byp_vk      = bus.cdb_b_data;
                byp_qk_busy = 1'b0;
            end
        end
    end

    // Entry wakeup, issue register and dispatch write; reset > stall > flush > normal update
    always_ff @(posedge clk) begin
        if (rst) begin
            busy          <= '0;
            qj_busy       <= '0;
            qk_busy       <= '0;
            full_q        <= 1'b0;
            exec_enable_q <= 1'b0;
            exec_op_q     <= '0;
            exec_reg1_q   <= '0;
            exec_reg2_q   <= '0;
            exec_imm_q    <= '0;
            exec_pc_q     <= '0;
            exec_dest_q   <= '0;
        end else if (!rdy) begin
            exec_enable_q <= 1'b0;
        end else if (clear) begin
            busy          <= '0;
            full_q        <= 1'b0;
            exec_enable_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && qj_busy[i]) begin
                    if (bus.cdb_a_valid && bus.cdb_a_tag == qj[i]) begin
                        vj[i]      <= bus.cdb_a_data;
                        qj_busy[i] <= 1'b0;
                    end else if (bus.cdb_b_valid && bus.cdb_b_tag == qj[i]) begin
                        vj[i]      <= bus.cdb_b_data;
                        qj_busy[i] <= 1'b0;
                    end
                end
                if (busy[i] && qk_busy[i]) begin
                    if (bus.cdb_a_valid && bus.cdb_a_tag == qk[i]) begin
                        vk[i]      <= bus.cdb_a_data;
                        qk_busy[i] <= 1'b0;
                    end else if (bus.cdb_b_valid && bus.cdb_b_tag == qk[i]) begin
                        vk[i]      <= bus.cdb_b_data;
                        qk_busy[i] <= 1'b0;
                    end
                end
            end

            if (issue_found) begin
                exec_enable_q <= 1'b1;
                exec_op_q     <= op[issue_idx];
                exec_reg1_q   <= vj[issue_idx];
                exec_reg2_q   <= vk[issue_idx];
                exec_imm_q    <= imm[issue_idx];
                exec_pc_q     <= pc[issue_idx];
                exec_dest_q   <= dest[issue_idx];
            end else begin
                exec_enable_q <= 1'b0;
            end

            if (do_disp) begin
                op[free_idx]      <= bus.disp_op;
                vj[free_idx]      <= byp_vj;
                vk[free_idx]      <= byp_vk;
                qj_busy[free_idx] <= byp_qj_busy;
                qk_busy[free_idx] <= byp_qk_busy;
                qj[free_idx]      <= bus.disp_qj;
                qk[free_idx]      <= bus.disp_qk;
                imm[free_idx]     <= bus.disp_imm;
                pc[free_idx]      <= bus.disp_pc;
                dest[free_idx]    <= bus.disp_dest;
            end

            busy   <= busy_nxt;
            full_q <= &busy_nxt;
        end
    end
endmodule

// File: tb/tb_branch_rs.sv
// tb/tb_branch_rs.sv - self-checking bench for branch_rs
module tb_branch_rs;
    localparam logic [5:0] OP_BEQ  = 6'd1;
    localparam logic [5:0] OP_BNE  = 6'd2;
    localparam logic [5:0] OP_BLT  = 6'd3;
    localparam logic [5:0] OP_JAL  = 6'd8;
    localparam logic [5:0] OP_JALR = 6'd9;

    logic clk;
    logic rst;
    logic rdy;
    logic clear;

    branch_rs_if #(.TAG_W(4), .OP_W(6), .DATA_W(32)) bus ();

    branch_rs #(.DEPTH(4), .TAG_W(4), .OP_W(6), .DATA_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  dest;
    } exp_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  dest;
        exp_t        exp;
    } vec_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.disp_valid   = 1'b0;
        bus.disp_op      = '0;
        bus.disp_vj      = '0;
        bus.disp_vk      = '0;
        bus.disp_qj_busy = 1'b0;
        bus.disp_qk_busy = 1'b0;
        bus.disp_qj      = '0;
        bus.disp_qk      = '0;
        bus.disp_imm     = '0;
        bus.disp_pc      = '0;
        bus.disp_dest    = '0;
        bus.cdb_a_valid  = 1'b0;
        bus.cdb_a_tag    = '0;
        bus.cdb_a_data   = '0;
        bus.cdb_b_valid  = 1'b0;
        bus.cdb_b_tag    = '0;
        bus.cdb_b_data   = '0;
        clear            = 1'b0;
        rdy              = 1'b1;
    endtask

    task automatic dispatch(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic qjb, input logic [3:0] qj,
                            input logic qkb, input logic [3:0] qk,
                            input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] dest);
        bus.disp_valid   = 1'b1;
        bus.disp_op      = op;
        bus.disp_vj      = vj;
        bus.disp_vk      = vk;
        bus.disp_qj_busy = qjb;
        bus.disp_qj      = qj;
        bus.disp_qk_busy = qkb;
        bus.disp_qk      = qk;
        bus.disp_imm     = imm;
        bus.disp_pc      = pc;
        bus.disp_dest    = dest;
    endtask

    task automatic push_exp(input logic [5:0] op, input logic [31:0] r1, input logic [31:0] r2,
                            input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] dest);
        exp_t e;
        e.op = op; e.r1 = r1; e.r2 = r2; e.imm = imm; e.pc = pc; e.dest = dest;
        exp_q.push_back(e);
    endtask

    task automatic expect_issue(input string name);
        exp_t e;
        chk({name, "_enable"}, 32'(bus.exec_enable), 32'd1);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard got=empty exp=entry", name);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_op"},   32'(bus.exec_op),   32'(e.op));
            chk({name, "_reg1"}, bus.exec_reg1,      e.r1);
            chk({name, "_reg2"}, bus.exec_reg2,      e.r2);
            chk({name, "_imm"},  bus.exec_imm,       e.imm);
            chk({name, "_pc"},   bus.exec_pc,        e.pc);
            chk({name, "_dest"}, 32'(bus.exec_dest), 32'(e.dest));
        end
    endtask

    task automatic expect_idle(input string name);
        chk({name, "_enable"}, 32'(bus.exec_enable), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        checks   = 0;
        failures = 0;

        vecs[0] = '{OP_BEQ,  32'd5,          32'd5,          32'd8,          32'h100,  4'd3,
                    '{OP_BEQ,  32'd5,          32'd5,          32'd8,          32'h100,  4'd3}};
        vecs[1] = '{OP_BNE,  32'hdead,       32'hbeef,       32'hffff_fff0,  32'h2000, 4'd7,
                    '{OP_BNE,  32'hdead,       32'hbeef,       32'hffff_fff0,  32'h2000, 4'd7}};
        vecs[2] = '{OP_JAL,  32'd0,          32'd0,          32'h40,         32'h300,  4'd15,
                    '{OP_JAL,  32'd0,          32'd0,          32'h40,         32'h300,  4'd15}};
        vecs[3] = '{OP_JALR, 32'h1234,       32'd0,          32'd4,          32'h400,  4'd0,
                    '{OP_JALR, 32'h1234,       32'd0,          32'd4,          32'h400,  4'd0}};

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_full",   32'(bus.full),        32'd0);
        chk("rst_enable", 32'(bus.exec_enable), 32'd0);
        chk("rst_op",     32'(bus.exec_op),     32'd0);
        chk("rst_reg1",   bus.exec_reg1,        32'd0);
        chk("rst_reg2",   bus.exec_reg2,        32'd0);
        chk("rst_imm",    bus.exec_imm,         32'd0);
        chk("rst_pc",     bus.exec_pc,          32'd0);
        chk("rst_dest",   32'(bus.exec_dest),   32'd0);
        rst = 1'b0;

        // ready dispatch: issue exactly one edge later, then drop
        for (int i = 0; i < 4; i++) begin
            dispatch(vecs[i].op, vecs[i].vj, vecs[i].vk, 1'b0, 4'd0, 1'b0, 4'd0,
                     vecs[i].imm, vecs[i].pc, vecs[i].dest);
            push_exp(vecs[i].exp.op, vecs[i].exp.r1, vecs[i].exp.r2,
                     vecs[i].exp.imm, vecs[i].exp.pc, vecs[i].exp.dest);
            tick();
            bus.disp_valid = 1'b0;
            expect_idle("vec_disp_cycle");
            tick();
            expect_issue("vec_issue");
            tick();
            expect_idle("vec_after");
        end

        // wakeup from cdb_a, issue two edges after the broadcast
        dispatch(OP_BNE, 32'hx, 32'd9, 1'b1, 4'd2, 1'b0, 4'd0, 32'h10, 32'h500, 4'd5);
        tick();
        bus.disp_valid  = 1'b0;
        bus.cdb_a_valid = 1'b1; bus.cdb_a_tag = 4'd2; bus.cdb_a_data = 32'h7;
        push_exp(OP_BNE, 32'h7, 32'd9, 32'h10, 32'h500, 4'd5);
        tick();
        bus.cdb_a_valid = 1'b0;
        expect_idle("wake_capture");
        tick();
        expect_issue("wake_a");
        tick();
        expect_idle("wake_a_after");

        // same tag on both buses: ALU bus wins
        dispatch(OP_BLT, 32'hx, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 32'h20, 32'h600, 4'd6);
        tick();
        bus.disp_valid  = 1'b0;
        bus.cdb_a_valid = 1'b1; bus.cdb_a_tag = 4'd2; bus.cdb_a_data = 32'h11;
        bus.cdb_b_valid = 1'b1; bus.cdb_b_tag = 4'd2; bus.cdb_b_data = 32'h22;
        push_exp(OP_BLT, 32'h11, 32'd1, 32'h20, 32'h600, 4'd6);
        tick();
        bus.cdb_a_valid = 1'b0; bus.cdb_b_valid = 1'b0;
        expect_idle("prio_capture");
        tick();
        expect_issue("prio");
        tick();

        // dispatch bypass from cdb_b on the dispatch edge
        dispatch(OP_BEQ, 32'h3, 32'hx, 1'b0, 4'd0, 1'b1, 4'd4, 32'h30, 32'h700, 4'd9);
        bus.cdb_b_valid = 1'b1; bus.cdb_b_tag = 4'd4; bus.cdb_b_data = 32'h55;
        push_exp(OP_BEQ, 32'h3, 32'h55, 32'h30, 32'h700, 4'd9);
        tick();
        bus.disp_valid = 1'b0; bus.cdb_b_valid = 1'b0;
        expect_idle("bypass_disp");
        tick();
        expect_issue("bypass");
        tick();

        // fill all entries with pending operands
        for (int i = 0; i < 4; i++) begin
            dispatch(OP_BNE, 32'hx, 32'(100 + i), 1'b1, 4'(8 + i), 1'b0, 4'd0,
                     32'(i), 32'h1000 + 32'(4 * i), 4'(i));
            tick();
            chk("fill_full", 32'(bus.full), (i == 3) ? 32'd1 : 32'd0);
        end
        dispatch(OP_JAL, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h8, 32'h9000, 4'd12);
        tick();
        bus.disp_valid = 1'b0;
        chk("full_ignore_full", 32'(bus.full), 32'd1);
        expect_idle("full_ignore_a");
        tick();
        expect_idle("full_ignore_b");
        bus.cdb_b_valid = 1'b1; bus.cdb_b_tag = 4'd10; bus.cdb_b_data = 32'hcafe;
        push_exp(OP_BNE, 32'hcafe, 32'd102, 32'd2, 32'h1008, 4'd2);
        tick();
        bus.cdb_b_valid = 1'b0;
        chk("e2_capture_full", 32'(bus.full), 32'd1);
        expect_idle("e2_capture");
        tick();
        expect_issue("e2_issue");
        chk("e2_full_drop", 32'(bus.full), 32'd0);

        // three entries remain busy; flush together with a dispatch
        dispatch(OP_JAL, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h8, 32'h9100, 4'd13);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        bus.disp_valid = 1'b0;
        chk("clear_full", 32'(bus.full), 32'd0);
        expect_idle("clear_enable");
        bus.cdb_a_valid = 1'b1; bus.cdb_a_tag = 4'd8;  bus.cdb_a_data = 32'h1;
        bus.cdb_b_valid = 1'b1; bus.cdb_b_tag = 4'd9;  bus.cdb_b_data = 32'h2;
        tick();
        expect_idle("clear_stale_a");
        bus.cdb_a_tag = 4'd11; bus.cdb_b_valid = 1'b0;
        tick();
        bus.cdb_a_valid = 1'b0;
        expect_idle("clear_stale_b");
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_idle("clear_stale_c");
        end

        // indices 1 and 3 become ready together; rdy stall in between
        dispatch(OP_BNE, 32'hx, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0, 32'd0, 32'h2000, 4'd1);
        tick();
        dispatch(OP_BLT, 32'hx, 32'd3, 1'b1, 4'd14, 1'b0, 4'd0, 32'h44, 32'h2004, 4'd2);
        tick();
        dispatch(OP_BNE, 32'hx, 32'd0, 1'b1, 4'd13, 1'b0, 4'd0, 32'd0, 32'h2008, 4'd3);
        tick();
        dispatch(OP_BEQ, 32'h77, 32'hx, 1'b0, 4'd0, 1'b1, 4'd14, 32'h48, 32'h200c, 4'd4);
        tick();
        bus.disp_valid = 1'b0;
        chk("two_full", 32'(bus.full), 32'd1);
        bus.cdb_b_valid = 1'b1; bus.cdb_b_tag = 4'd14; bus.cdb_b_data = 32'h99;
        push_exp(OP_BLT, 32'h99, 32'd3, 32'h44, 32'h2004, 4'd2);
        push_exp(OP_BEQ, 32'h77, 32'h99, 32'h48, 32'h200c, 4'd4);
        tick();
        bus.cdb_b_valid = 1'b0;
        expect_idle("two_capture");
        tick();
        expect_issue("two_first");
        chk("two_full_after", 32'(bus.full), 32'd0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_idle("stall");
        end
        rdy = 1'b1;
        tick();
        expect_issue("two_second");
        tick();
        expect_idle("two_after");

        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("end_full", 32'(bus.full), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
